// File: rtl/mem_pkg.sv
// Shared defaults and the response record for the memory response pipeline
// and the cache-fill logic that will consume it.
package mem_pkg;
  localparam int MEM_ADDR_W  = 16;
  localparam int MEM_DATA_W  = 16;
  localparam int MEM_TAG_W   = 2;
  localparam int MEM_LATENCY = 4;

  typedef struct packed {
    logic                  valid;
    logic [MEM_TAG_W-1:0]  tag;
    logic [MEM_DATA_W-1:0] data;
  } mem_resp_t;
endpackage

// File: rtl/mem_resp_pipe_if.sv
// CPU memory request/response bus. The CPU is the master; the memory is the slave.
interface mem_resp_pipe_if #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 16,
  parameter int TAG_WIDTH  = 2
);
  logic                  enable;
  logic                  wr;
  logic [ADDR_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] data_in;
  logic [TAG_WIDTH-1:0]  req_tag;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  data_valid;
  logic [TAG_WIDTH-1:0]  resp_tag;
  logic [3:0]            outstanding;

  modport master (output enable, wr, addr, data_in, req_tag,
                  input  data_out, data_valid, resp_tag, outstanding);
  modport slave  (input  enable, wr, addr, data_in, req_tag,
                  output data_out, data_valid, resp_tag, outstanding);
endinterface

// File: rtl/mem_pipe_stage.sv
// One response pipeline register. Payload only loads when the incoming entry
// is valid, so the last stage naturally holds data_out/resp_tag across bubbles.
module mem_pipe_stage
  import mem_pkg::*;
#(
  parameter type T = mem_resp_t
) (
  input  logic clk,
  input  logic rst_n,
  input  T     i_d,
  output T     o_q
);
  T r_q;

  // Advance valid every cycle; capture payload only with a valid entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         r_q       <= '0;
    else if (i_d.valid) r_q       <= i_d;
    else                r_q.valid <= 1'b0;
  end

  assign o_q = r_q;
endmodule

// File: rtl/mem_resp_pipe.sv
// Fixed-latency word memory: one request per cycle, reads return in order
// exactly LATENCY cycles after acceptance with the request tag echoed.
module mem_resp_pipe
  import mem_pkg::*;
#(
  parameter int    ADDR_WIDTH = MEM_ADDR_W,
  parameter int    DATA_WIDTH = MEM_DATA_W,
  parameter int    MEM_WORDS  = 65536/2,
  parameter int    LATENCY    = MEM_LATENCY,
  parameter int    TAG_WIDTH  = MEM_TAG_W,
  parameter string INIT_FILE  = ""
) (
  input logic            clk,
  input logic            rst_n,
  mem_resp_pipe_if.slave bus
);
  localparam int IDX_W = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;

  // Local record sized to this instance; same layout as mem_resp_t.
  typedef struct packed {
    logic                  valid;
    logic [TAG_WIDTH-1:0]  tag;
    logic [DATA_WIDTH-1:0] data;
  } resp_t;

  logic [DATA_WIDTH-1:0] r_mem [MEM_WORDS];
  logic [ADDR_WIDTH-2:0] w_word;
  logic [IDX_W-1:0]      w_idx;
  logic                  w_rd_acc;
  logic                  w_wr_acc;
  resp_t                 w_stg [LATENCY+1];
  logic [LATENCY:0]      w_vld_pipe;
  logic [3:0]            r_outst;

  // Byte address -> word index; out-of-range words alias modulo MEM_WORDS.
  assign w_word   = bus.addr[ADDR_WIDTH-1:1];
  assign w_idx    = IDX_W'(32'(w_word) % 32'(MEM_WORDS));
  assign w_rd_acc = bus.enable & ~bus.wr;
  assign w_wr_acc = bus.enable &  bus.wr;

  // Write port: commits at the accepting edge.
  always_ff @(posedge clk) begin
    if (w_wr_acc) r_mem[w_idx] <= bus.data_in;
  end

  // Stage 0 input: the word is sampled at acceptance, so later writes
  // cannot disturb data already in flight.
  always_comb begin
    w_stg[0]       = '0;
    w_stg[0].valid = w_rd_acc;
    w_stg[0].tag   = bus.req_tag;
    w_stg[0].data  = r_mem[w_idx];
  end

  genvar gi;
  generate
    for (gi = 0; gi < LATENCY; gi++) begin : g_stg
      mem_pipe_stage #(.T(resp_t)) u_stg (
        .clk   (clk),
        .rst_n (rst_n),
        .i_d   (w_stg[gi]),
        .o_q   (w_stg[gi+1])
      );
    end
    for (gi = 0; gi <= LATENCY; gi++) begin : g_vld
      assign w_vld_pipe[gi] = w_stg[gi].valid;
    end
  endgenerate

  // In-flight read count: +1 on acceptance, -1 as the strobe cycle retires.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_outst <= '0;
    else        r_outst <= r_outst + 4'(w_rd_acc) - 4'(w_vld_pipe[LATENCY]);
  end

  assign bus.data_valid  = w_vld_pipe[LATENCY];
  assign bus.data_out    = w_stg[LATENCY].data;
  assign bus.resp_tag    = w_stg[LATENCY].tag;
  assign bus.outstanding = r_outst;
endmodule

// File: tb/tb_mem_resp_pipe.sv
// Directed bench for mem_resp_pipe. Inputs change and outputs are sampled on
// the falling edge; a second instance with MEM_WORDS=256 shares the stimulus
// so address aliasing can be observed.
module tb_mem_resp_pipe;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_run = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  mem_resp_pipe_if #(.ADDR_WIDTH(16), .DATA_WIDTH(16), .TAG_WIDTH(2)) bus  ();
  mem_resp_pipe_if #(.ADDR_WIDTH(16), .DATA_WIDTH(16), .TAG_WIDTH(2)) bus2 ();

  assign bus2.enable  = bus.enable;
  assign bus2.wr      = bus.wr;
  assign bus2.addr    = bus.addr;
  assign bus2.data_in = bus.data_in;
  assign bus2.req_tag = bus.req_tag;

  mem_resp_pipe dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  mem_resp_pipe #(.MEM_WORDS(256)) dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2));

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic drv(input logic en, input logic w, input logic [15:0] a,
                     input logic [15:0] d, input logic [1:0] t);
    bus.enable  = en;
    bus.wr      = w;
    bus.addr    = a;
    bus.data_in = d;
    bus.req_tag = t;
  endtask

  task automatic idle();
    drv(1'b0, 1'b0, 16'h0, 16'h0, 2'd0);
  endtask

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_run++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  // Strobe check; data and tag are only meaningful when a strobe is expected.
  task automatic rsp(input string nm, input logic v, input logic [15:0] d,
                     input logic [1:0] t, input logic [3:0] o);
    chk({nm, ".valid"}, 32'(bus.data_valid), 32'(v));
    chk({nm, ".outst"}, 32'(bus.outstanding), 32'(o));
    if (v) begin
      chk({nm, ".data"}, 32'(bus.data_out), 32'(d));
      chk({nm, ".tag"},  32'(bus.resp_tag), 32'(t));
    end
  endtask

  task automatic wr_word(input logic [15:0] a, input logic [15:0] d);
    drv(1'b1, 1'b1, a, d, 2'd0);
    tick();
    idle();
  endtask

  initial begin
    idle();
    // Reset state
    tick(); tick();
    chk("rst.valid", 32'(bus.data_valid), 32'd0);
    chk("rst.outst", 32'(bus.outstanding), 32'd0);
    chk("rst.data",  32'(bus.data_out), 32'd0);
    chk("rst.tag",   32'(bus.resp_tag), 32'd0);
    rst_n = 1'b1;
    tick();

    // Preload
    wr_word(16'h0000, 16'h1111);
    wr_word(16'h0002, 16'h2222);
    wr_word(16'h0004, 16'h3333);
    wr_word(16'h0006, 16'h4444);
    wr_word(16'h0020, 16'h00AA);
    wr_word(16'h0040, 16'h7777);
    tick();

    // Write then read-after-write, latency 4
    drv(1'b1, 1'b1, 16'h0010, 16'hBEEF, 2'd1); tick();
    rsp("raw.w", 1'b0, 16'h0, 2'd0, 4'd0);
    drv(1'b1, 1'b0, 16'h0010, 16'h0, 2'd2); tick();
    idle();
    rsp("raw.c1", 1'b0, 16'h0, 2'd0, 4'd1); tick();
    rsp("raw.c2", 1'b0, 16'h0, 2'd0, 4'd1); tick();
    rsp("raw.c3", 1'b0, 16'h0, 2'd0, 4'd1); tick();
    rsp("raw.c4", 1'b1, 16'hBEEF, 2'd2, 4'd1); tick();
    rsp("raw.c5", 1'b0, 16'h0, 2'd0, 4'd0);
    chk("raw.hold", 32'(bus.data_out), 32'hBEEF);

    // Four back-to-back reads
    drv(1'b1, 1'b0, 16'h0000, 16'h0, 2'd0); tick();
    rsp("b2b.c1", 1'b0, 16'h0, 2'd0, 4'd1);
    drv(1'b1, 1'b0, 16'h0002, 16'h0, 2'd1); tick();
    rsp("b2b.c2", 1'b0, 16'h0, 2'd0, 4'd2);
    drv(1'b1, 1'b0, 16'h0004, 16'h0, 2'd2); tick();
    rsp("b2b.c3", 1'b0, 16'h0, 2'd0, 4'd3);
    drv(1'b1, 1'b0, 16'h0006, 16'h0, 2'd3); tick();
    idle();
    rsp("b2b.c4", 1'b1, 16'h1111, 2'd0, 4'd4); tick();
    rsp("b2b.c5", 1'b1, 16'h2222, 2'd1, 4'd3); tick();
    rsp("b2b.c6", 1'b1, 16'h3333, 2'd2, 4'd2); tick();
    rsp("b2b.c7", 1'b1, 16'h4444, 2'd3, 4'd1); tick();
    rsp("b2b.c8", 1'b0, 16'h0, 2'd0, 4'd0);
    chk("b2b.hold", 32'(bus.data_out), 32'h4444);

    // Read, then overwrite while in flight
    drv(1'b1, 1'b0, 16'h0020, 16'h0, 2'd1); tick();
    drv(1'b1, 1'b1, 16'h0020, 16'h5555, 2'd0); tick();
    idle(); tick(); tick();
    rsp("war.old", 1'b1, 16'h00AA, 2'd1, 4'd1);
    drv(1'b1, 1'b0, 16'h0020, 16'h0, 2'd3); tick();
    idle(); tick(); tick(); tick();
    rsp("war.new", 1'b1, 16'h5555, 2'd3, 4'd1);
    tick();

    // Read, bubble, read
    drv(1'b1, 1'b0, 16'h0000, 16'h0, 2'd1); tick();
    idle();
    rsp("bub.c1", 1'b0, 16'h0, 2'd0, 4'd1); tick();
    rsp("bub.c2", 1'b0, 16'h0, 2'd0, 4'd1);
    drv(1'b1, 1'b0, 16'h0002, 16'h0, 2'd2); tick();
    idle();
    rsp("bub.c3", 1'b0, 16'h0, 2'd0, 4'd2); tick();
    rsp("bub.c4", 1'b1, 16'h1111, 2'd1, 4'd2); tick();
    rsp("bub.c5", 1'b0, 16'h0, 2'd0, 4'd1); tick();
    rsp("bub.c6", 1'b1, 16'h2222, 2'd2, 4'd1); tick();
    rsp("bub.c7", 1'b0, 16'h0, 2'd0, 4'd0);

    // Reset with two reads in flight
    drv(1'b1, 1'b0, 16'h0000, 16'h0, 2'd1); tick();
    drv(1'b1, 1'b0, 16'h0002, 16'h0, 2'd2); tick();
    idle();
    rst_n = 1'b0; tick();
    rsp("mrst.c0", 1'b0, 16'h0, 2'd0, 4'd0);
    chk("mrst.data", 32'(bus.data_out), 32'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      rsp("mrst.quiet", 1'b0, 16'h0, 2'd0, 4'd0);
    end
    drv(1'b1, 1'b0, 16'h0040, 16'h0, 2'd3); tick();
    idle(); tick(); tick(); tick();
    rsp("mrst.keep", 1'b1, 16'h7777, 2'd3, 4'd1);
    tick();

    // Bit 0 of the address is ignored
    drv(1'b1, 1'b0, 16'h0011, 16'h0, 2'd0); tick();
    drv(1'b1, 1'b0, 16'h0010, 16'h0, 2'd1); tick();
    idle(); tick(); tick();
    rsp("odd.0011", 1'b1, 16'hBEEF, 2'd0, 4'd2); tick();
    rsp("odd.0010", 1'b1, 16'hBEEF, 2'd1, 4'd1); tick();

    // Aliasing on the 256-word instance: 0x0210 maps to word 8
    wr_word(16'h0010, 16'h1234);
    drv(1'b1, 1'b0, 16'h0210, 16'h0, 2'd2); tick();
    idle(); tick(); tick(); tick();
    chk("alias.valid", 32'(bus2.data_valid), 32'd1);
    chk("alias.data",  32'(bus2.data_out), 32'h1234);
    chk("alias.tag",   32'(bus2.resp_tag), 32'd2);
    tick();
    chk("alias.outst", 32'(bus2.outstanding), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
